// File: rtl/ahb_dma_master.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_dma_master
//  Purpose  : Single-channel AHB-lite DMA master. Copies a block of 32-bit
//             words from a source to a destination address using strictly
//             non-pipelined single NONSEQ transfers (one read, then one write
//             per word). Completion is flagged with a one-cycle done pulse.
//  Ports    : HCLK, HRESET     - bus clock, asynchronous active-high reset
//             start, src_addr, dst_addr, word_count
//                              - job request, sampled only while idle
//             busy, done, error
//                              - job status (error is sticky until next start)
//             HADDR, HTRANS, HWRITE, HSIZE, HWDATA
//                              - AHB-lite master request outputs
//             HRDATA, HREADY, HRESP
//                              - AHB-lite fabric responses
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_dma_master #(
    parameter int CNT_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RA   = 3'd1;   // read address phase
    localparam logic [2:0] c_ST_RD   = 3'd2;   // read data phase
    localparam logic [2:0] c_ST_WA   = 3'd3;   // write address phase
    localparam logic [2:0] c_ST_WD   = 3'd4;   // write data phase
    localparam logic [2:0] c_ST_DONE = 3'd5;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] c_HSIZE_WORD    = 3'b010;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [CNT_W-1:0] r_remain;
    logic [31:0]      r_buf;
    logic             r_error;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. An ERROR response terminates the job in whichever
    // data-phase cycle it appears, so HRESP is tested ahead of HREADY.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (word_count == '0) ? c_ST_DONE : c_ST_RA;
                end
            end
            c_ST_RA: begin
                if (HREADY) begin
                    w_state_nxt = c_ST_RD;
                end
            end
            c_ST_RD: begin
                if (HRESP) begin
                    w_state_nxt = c_ST_DONE;
                end else if (HREADY) begin
                    w_state_nxt = c_ST_WA;
                end
            end
            c_ST_WA: begin
                if (HREADY) begin
                    w_state_nxt = c_ST_WD;
                end
            end
            c_ST_WD: begin
                if (HRESP) begin
                    w_state_nxt = c_ST_DONE;
                end else if (HREADY) begin
                    w_state_nxt = (r_remain == c_CNT_ONE) ? c_ST_DONE : c_ST_RA;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decode purely from registered state; nothing from the
    // fabric response reaches an output combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        HTRANS = c_HTRANS_IDLE;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
        busy   = (r_state != c_ST_IDLE);
        done   = (r_state == c_ST_DONE);
        case (r_state)
            c_ST_RA: begin
                HTRANS = c_HTRANS_NONSEQ;
                HADDR  = r_src;
            end
            c_ST_RD: begin
                HADDR  = r_src;
            end
            c_ST_WA: begin
                HTRANS = c_HTRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = r_dst;
            end
            c_ST_WD: begin
                HADDR  = r_dst;
            end
            default: begin
            end
        endcase
    end

    assign HSIZE  = c_HSIZE_WORD;
    assign HWDATA = r_buf;
    assign error  = r_error;

    // ------------------------------------------------------------------
    // Job datapath: address pointers, remaining count, data buffer, error
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_src    <= 32'h0;
            r_dst    <= 32'h0;
            r_remain <= '0;
            r_buf    <= 32'h0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        if (word_count != '0) begin
                            // Byte offset is dropped: all accesses are word aligned.
                            r_src    <= src_addr & 32'hFFFF_FFFC;
                            r_dst    <= dst_addr & 32'hFFFF_FFFC;
                            r_remain <= word_count;
                        end
                    end
                end
                c_ST_RD: begin
                    if (HRESP) begin
                        r_error <= 1'b1;
                    end else if (HREADY) begin
                        r_buf <= HRDATA;
                    end
                end
                c_ST_WD: begin
                    if (HRESP) begin
                        r_error <= 1'b1;
                    end else if (HREADY) begin
                        // 32-bit wrap-around is intentional.
                        r_src    <= r_src + 32'd4;
                        r_dst    <= r_dst + 32'd4;
                        r_remain <= r_remain - c_CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
